// File: rtl/seq_divider_32.sv
// seq_divider_32: 32-bit unsigned restoring divider, one quotient bit per clock.
module CLA_Array_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [31:0] g, p, c;
  logic [7:0] gg, gp;
  logic [8:0] gc;
  assign g = a & b;
  assign p = a ^ b;
  // Two-level lookahead: 4-bit groups, group carries chained from group generate/propagate.
  always_comb begin
    gc = '0;
    gg = '0;
    gp = '0;
    c = '0;
    gc[0] = cin;
    for (int k = 0; k < 8; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
      c[4*k] = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
  end
  assign sum = p ^ c;
  assign cout = gc[8];
endmodule

module seq_divider_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [4:0] cnt;
  logic [31:0] dvd, dsr, r, sum, r_nx;
  logic cout, ge, accept, last;
  assign accept = start & (state != RUN);
  assign last = cnt == 5'd31;
  // Trial subtract of the 33-bit partial remainder; P[32] is r[31].
  CLA_Array_32 u_cla (
    .a({r[30:0], dvd[31]}),
    .b(~dsr),
    .cin(1'b1),
    .sum(sum),
    .cout(cout)
  );
  assign ge = r[31] | cout;
  assign r_nx = ge ? sum : {r[30:0], dvd[31]};
  assign busy = state == RUN;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = IDLE;
    state_nx = (state == RUN) ? (last ? DONE : RUN)
             : accept ? ((divisor == '0) ? DONE : RUN) : IDLE;
  end
  // dvd shifts dividend bits out the top while quotient bits enter at the bottom.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      dvd <= '0;
      dsr <= '0;
      r <= '0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
      dvd <= dividend;
      dsr <= divisor;
      r <= '0;
      if (divisor == '0) begin
        quotient <= '1;
        remainder <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == RUN) begin
      cnt <= cnt + 5'd1;
      dvd <= {dvd[30:0], ge};
      r <= r_nx;
      if (last) begin
        quotient <= {dvd[30:0], ge};
        remainder <= r_nx;
        div_by_zero <= 1'b0;
      end
    end
endmodule

// File: tb/tb_seq_divider_32.sv
// tb_seq_divider_32: directed and randomized checks of seq_divider_32 against an arithmetic model.
module tb_seq_divider_32;
  logic clk = 0, rst_n = 0, start = 0;
  logic [31:0] dividend = 0, divisor = 0;
  logic busy, done, div_by_zero;
  logic [31:0] quotient, remainder;
  int tests = 0, fails = 0;

  seq_divider_32 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return {32'hFFFFFFFF, a, 1'b1};
    return {a / b, a % b, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat = 0;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1 lat++;
    end
  endtask

  // Called 1 time unit after a rising edge; the next edge accepts.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b, input bit full);
    int lat, bcnt;
    start = 1;
    dividend = a;
    divisor = b;
    @(posedge clk);
    #1 start = 0;
    wait_done(lat, bcnt);
    if (full) begin
      chk({tag, "_done_edges"}, 65'(lat + 1), (b == 0) ? 65'd1 : 65'd33);
      chk({tag, "_busy_cycles"}, 65'(bcnt), (b == 0) ? 65'd0 : 65'd32);
    end
    chk({tag, "_result"}, {quotient, remainder, div_by_zero}, model(a, b));
  endtask

  initial begin
    int lat, bcnt;
    logic [31:0] a, b;
    repeat (2) @(posedge clk);
    #1 chk("reset_outputs", {30'd0, busy, done, quotient, remainder, div_by_zero}, 65'd0);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    do_op("div_100_7", 32'd100, 32'd7, 1);
    chk("q_100_7", 65'(quotient), 65'd14);
    chk("r_100_7", 65'(remainder), 65'd2);
    @(posedge clk);
    #1 chk("done_single_pulse", {63'd0, done, busy}, 65'd0);
    chk("result_held", {quotient, remainder, div_by_zero}, {32'd14, 32'd2, 1'b0});
    do_op("max_by_1", 32'hFFFFFFFF, 32'd1, 1);
    do_op("3_by_10", 32'd3, 32'd10, 1);
    do_op("0_by_5", 32'd0, 32'd5, 1);
    do_op("5_by_0", 32'd5, 32'd0, 1);
    chk("r_5_0", 65'(remainder), 65'd5);
    do_op("max_by_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    do_op("0_by_0", 32'd0, 32'd0, 1);
    // A start during RUN must not restart or corrupt the operation.
    start = 1;
    dividend = 32'd1000;
    divisor = 32'd3;
    @(posedge clk);
    #1 dividend = 32'd9;
    divisor = 32'd9;
    chk("hold_during_run", {quotient, remainder, div_by_zero}, {32'hFFFFFFFF, 32'd0, 1'b1});
    repeat (3) @(posedge clk);
    #1 start = 0;
    wait_done(lat, bcnt);
    chk("ignored_start_edges", 65'(lat + 4), 65'd33);
    chk("ignored_start_result", {quotient, remainder, div_by_zero}, {32'd333, 32'd1, 1'b0});
    do_op("b2b_9_9", 32'd9, 32'd9, 1);
    // Reset mid-RUN aborts with no done.
    start = 1;
    dividend = 32'd12345678;
    divisor = 32'd17;
    @(posedge clk);
    #1 start = 0;
    repeat (9) @(posedge clk);
    #1 rst_n = 0;
    #1 chk("async_reset", {30'd0, busy, done, quotient, remainder, div_by_zero}, 65'd0);
    @(posedge clk);
    #1 chk("no_done_in_reset", {64'd0, done}, 65'd0);
    @(negedge clk) rst_n = 1;
    do_op("after_reset", 32'd12345678, 32'd17, 1);
    chk("q_after_reset", {quotient, remainder, div_by_zero}, {32'd726216, 32'd6, 1'b0});
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = ($urandom_range(15) == 0) ? 32'd0 : ($urandom >> $urandom_range(31));
      if (i == 0) a = 32'hFFFFFFFF;
      if (i == 1) a = 32'd0;
      do_op("random", a, b, (i % 50) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    if (fails == 0) $display("Test passed");
    $finish;
  end
endmodule
